i2c_master_param: RTL and testbench

Parametrised I2C master controller that generates SCL internally from the system clock and runs complete multi-byte write or read transactions (START, address, data, ACK/NACK, STOP) under a simple start/busy/done handshake. It replaces the fixed divider plus single-mode master pair at the top of the I2C test design. It drives the bus through open-drain enables, so the top level wires it to pulled-up `sda`/`scl` nets with tri-state buffers. The PmodCDC1 client model sits on the same nets.

---
 rtl/i2c_master_param.sv | 256 +++++++++++++++++++++++++
 tb/tb_i2c_master_param.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_param.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_master_param
//
// Purpose: I2C master that generates SCL from the system clock and runs a
// complete write or read transaction (START, address, up to MAX_BYTES data
// bytes with ACK/NACK, STOP). The bus is driven open-drain: an *_oe of 1
// pulls the line low, 0 releases it to the external pull-up.
//
// Configuration macro: I2C_CLOCK_STRETCH_EN
//   defined   - the quarter counter holds in q2 while scl_in is low, so a
//               slave may stretch the clock.
//   undefined - scl_in is ignored and bus timing is fixed.
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   start        request a transaction (taken in IDLE only)
//   rw           0 = write, 1 = read (captured with start)
//   addr         7-bit slave address (captured with start)
//   nbytes       data byte count, clamped to MAX_BYTES (captured with start)
//   wdata        write bytes, byte k at [8k+7:8k] (captured with start)
//   rdata        read bytes, same layout; held until the next read
//   busy         high from the cycle after start is taken until done
//   done         one-cycle pulse at the end of a transaction
//   ack_err      slave NACK seen in the last transaction, held to next start
//   scl_oe       1 = pull SCL low
//   sda_oe       1 = pull SDA low
//   scl_in       sampled SCL level
//   sda_in       sampled SDA level
//   state_dbg    current FSM state encoding
//
// Handshake: start is accepted only while the FSM is in IDLE (busy low);
// busy rises on the next cycle. done pulses for one cycle in the same cycle
// busy falls; rdata and ack_err are valid from that cycle on. A new start is
// accepted on the cycle after done.
//
// Bus timing: every bit (ACK included) takes four quarters: q0 SCL low with
// SDA updated, q1 SCL low, q2 and q3 SCL released; sda_in is sampled on the
// first cycle of q3. START is two quarters, STOP is three.
// ---------------------------------------------------------------------------
module i2c_master_param #(
    parameter int QUARTER_DIV = 250,
    parameter int MAX_BYTES   = 4,
    parameter int LEN_W       = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   rw,
    input  logic [6:0]             addr,
    input  logic [LEN_W-1:0]       nbytes,
    input  logic [8*MAX_BYTES-1:0] wdata,
    output logic [8*MAX_BYTES-1:0] rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_err,
    output logic                   scl_oe,
    output logic                   sda_oe,
    input  logic                   scl_in,
    input  logic                   sda_in,
    output logic [3:0]             state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE, S_WACK, S_READ, S_MACK, S_STOP
    } state_t;

    localparam int             QW    = $clog2(QUARTER_DIV);
    localparam logic [QW-1:0]  QLAST = QW'(QUARTER_DIV - 1);
    localparam logic [LEN_W-1:0] NMAX = LEN_W'(MAX_BYTES);

    state_t                 state;
    logic [QW-1:0]          qcnt;
    logic [1:0]             quarter;
    logic [2:0]             bit_cnt;
    logic [LEN_W-1:0]       byte_cnt;
    logic [LEN_W-1:0]       n_lat;
    logic                   rw_lat;
    logic [7:0]             tx_sh;
    logic [7:0]             rx_sh;
    logic [8*MAX_BYTES-1:0] wbuf;
    logic                   ack_bit;

    logic bit_phase;
    logic stall;
    logic tick;
    logic last_byte;

    assign state_dbg = state;
    assign bit_phase = (state != S_IDLE) && (state != S_START) && (state != S_STOP);
    assign last_byte = (byte_cnt == n_lat - LEN_W'(1));

`ifdef I2C_CLOCK_STRETCH_EN
    // SCL has been released in q2; a low level means a slave is holding it.
    assign stall = bit_phase && (quarter == 2'd2) && !scl_in;
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign stall      = 1'b0;
`endif

    assign tick = (qcnt == QLAST) && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            qcnt     <= '0;
            quarter  <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            n_lat    <= '0;
            rw_lat   <= 1'b0;
            tx_sh    <= 8'd0;
            rx_sh    <= 8'd0;
            wbuf     <= '0;
            ack_bit  <= 1'b1;
            rdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                qcnt    <= '0;
                quarter <= 2'd0;
                if (start) begin
                    state    <= S_START;
                    busy     <= 1'b1;
                    ack_err  <= 1'b0;
                    rw_lat   <= rw;
                    tx_sh    <= {addr, rw};
                    n_lat    <= (nbytes > NMAX) ? NMAX : nbytes;
                    wbuf     <= wdata;
                    byte_cnt <= '0;
                    scl_oe   <= 1'b0;
                    sda_oe   <= 1'b0;
                end
            end else begin
                if (tick)
                    qcnt <= '0;
                else if (!stall)
                    qcnt <= qcnt + 1'b1;

                if (bit_phase && quarter == 2'd3 && qcnt == '0) begin
                    ack_bit <= sda_in;
                    rx_sh   <= {rx_sh[6:0], sda_in};
                end

                if (tick) begin
                    case (state)
                        S_START: begin
                            if (quarter == 2'd0) begin
                                quarter <= 2'd1;
                                sda_oe  <= 1'b1;
                            end else begin
                                state   <= S_ADDR;
                                quarter <= 2'd0;
                                bit_cnt <= 3'd7;
                                scl_oe  <= 1'b1;
                                sda_oe  <= ~tx_sh[7];
                            end
                        end
                        S_STOP: begin
                            quarter <= quarter + 2'd1;
                            if (quarter == 2'd0) begin
                                scl_oe <= 1'b0;
                            end else if (quarter == 2'd1) begin
                                sda_oe <= 1'b0;
                            end else begin
                                state   <= S_IDLE;
                                quarter <= 2'd0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end
                        end
                        default: begin
                            if (quarter != 2'd3) begin
                                quarter <= quarter + 2'd1;
                                if (quarter == 2'd1)
                                    scl_oe <= 1'b0;
                            end else begin
                                // End of a bit: SCL goes low and SDA takes the
                                // level of whatever comes next.
                                quarter <= 2'd0;
                                scl_oe  <= 1'b1;
                                case (state)
                                    S_ADDR, S_WRITE: begin
                                        if (bit_cnt == 3'd0) begin
                                            state  <= (state == S_ADDR) ? S_ADDR_ACK : S_WACK;
                                            sda_oe <= 1'b0;
                                        end else begin
                                            bit_cnt <= bit_cnt - 3'd1;
                                            tx_sh   <= {tx_sh[6:0], 1'b0};
                                            sda_oe  <= ~tx_sh[6];
                                        end
                                    end
                                    S_ADDR_ACK, S_WACK: begin
                                        if (ack_bit) begin
                                            ack_err <= 1'b1;
                                            state   <= S_STOP;
                                            sda_oe  <= 1'b1;
                                        end else if ((state == S_ADDR_ACK && n_lat == '0) ||
                                                     (state == S_WACK && last_byte)) begin
                                            state  <= S_STOP;
                                            sda_oe <= 1'b1;
                                        end else if (state == S_ADDR_ACK && rw_lat) begin
                                            state    <= S_READ;
                                            bit_cnt  <= 3'd7;
                                            byte_cnt <= '0;
                                            sda_oe   <= 1'b0;
                                        end else begin
                                            // wbuf is consumed one byte at a time from the bottom.
                                            state    <= S_WRITE;
                                            bit_cnt  <= 3'd7;
                                            byte_cnt <= (state == S_ADDR_ACK) ? '0 : byte_cnt + LEN_W'(1);
                                            tx_sh    <= wbuf[7:0];
                                            wbuf     <= wbuf >> 8;
                                            sda_oe   <= ~wbuf[7];
                                        end
                                    end
                                    S_READ: begin
                                        if (bit_cnt == 3'd0) begin
                                            for (int k = 0; k < MAX_BYTES; k++)
                                                if (byte_cnt == LEN_W'(k))
                                                    rdata[8*k +: 8] <= rx_sh;
                                            state  <= S_MACK;
                                            // ACK every byte but the last, which gets NACK.
                                            sda_oe <= ~last_byte;
                                        end else begin
                                            bit_cnt <= bit_cnt - 3'd1;
                                        end
                                    end
                                    S_MACK: begin
                                        if (last_byte) begin
                                            state  <= S_STOP;
                                            sda_oe <= 1'b1;
                                        end else begin
                                            state    <= S_READ;
                                            bit_cnt  <= 3'd7;
                                            byte_cnt <= byte_cnt + LEN_W'(1);
                                            sda_oe   <= 1'b0;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_param.sv
`timescale 1ns/1ps
// Bench for i2c_master_param: a bus-level slave model on open-drain nets,
// a vector table of transactions, randomized transactions, and hand-written
// reset / ignored-start / clock-stretch sequences.
module tb_i2c_master_param;

  localparam int QDIV = 4;
  localparam int MAXB = 4;
  localparam int LW   = $clog2(MAXB + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start, rw;
  logic [6:0]    addr;
  logic [LW-1:0] nbytes;
  logic [31:0]   wdata, rdata;
  logic          busy, done, ack_err, scl_oe, sda_oe;
  logic [3:0]    state_dbg;

  logic sl_sda_low, sl_scl_low;
  wire  scl_bus = ~scl_oe & ~sl_scl_low;
  wire  sda_bus = ~sda_oe & ~sl_sda_low;

  i2c_master_param #(.QUARTER_DIV(QDIV), .MAX_BYTES(MAXB), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr),
    .nbytes(nbytes), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .ack_err(ack_err), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_in(scl_bus), .sda_in(sda_bus), .state_dbg(state_dbg)
  );

  // ---------------- slave model ----------------
  logic        cfg_present = 1'b1;
  int          cfg_nack    = -1;
  logic [31:0] cfg_rd      = '0;
  logic        cfg_stretch = 1'b0;

  logic        scl_p, sda_p, s_rw, active, rd_done, st_done;
  int          bitn, bytes_n, stretch_cnt;
  logic [7:0]  sh;
  logic [7:0]  bus_bytes[$];
  logic        mack_q[$];
  int          stop_cnt = 0;

  always @(negedge clk) begin : slave
    logic sc, sd;
    sc = scl_bus;
    sd = sda_bus;
    if (reset) begin
      active = 0; sl_sda_low = 0; sl_scl_low = 0; stretch_cnt = 0;
      scl_p = 1; sda_p = 1; bitn = 0; bytes_n = 0; rd_done = 0; st_done = 0;
      s_rw = 0; sh = 0;
    end else begin
      if (sc && scl_p && sda_p && !sd) begin
        active = 1; bitn = 0; bytes_n = 0; rd_done = 0; st_done = 0;
        sl_sda_low = 0; bus_bytes.delete(); mack_q.delete();
      end else if (sc && scl_p && !sda_p && sd) begin
        active = 0; sl_sda_low = 0; stop_cnt++;
      end else if (active && sc && !scl_p) begin
        if (bitn < 8) begin
          sh = {sh[6:0], sd};
          bitn++;
          if (bitn == 8 && (bytes_n == 0 || !s_rw)) bus_bytes.push_back(sh);
          if (bitn == 8 && bytes_n == 0) s_rw = sh[0];
        end else begin
          if (bytes_n > 0 && s_rw) begin
            mack_q.push_back(sd);
            if (sd) rd_done = 1;
          end
          bitn = 0;
          bytes_n++;
        end
      end else if (active && !sc && scl_p) begin
        if (cfg_stretch && !st_done && bytes_n == 1 && bitn == 4 && !s_rw) begin
          stretch_cnt = 2 * QDIV + 50;
          st_done = 1;
        end
        if (bitn == 8) begin
          if (bytes_n == 0)  sl_sda_low = cfg_present;
          else if (!s_rw)    sl_sda_low = ((bytes_n - 1) != cfg_nack);
          else               sl_sda_low = 0;
        end else if (bytes_n > 0 && bytes_n <= MAXB && s_rw && !rd_done && cfg_present) begin
          sl_sda_low = ~cfg_rd[8 * (bytes_n - 1) + 7 - bitn];
        end else begin
          sl_sda_low = 0;
        end
      end
      if (stretch_cnt > 0) begin
        sl_scl_low = 1;
        stretch_cnt--;
      end else begin
        sl_scl_low = 0;
      end
      scl_p = sc;
      sda_p = sd;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_miscmp = 0;
  logic [7:0]  exp_q[$];
  logic        exp_mack[$];
  logic [31:0] rdata_model = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_miscmp++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference outcome from the protocol rules: m = data bytes that appear on the bus.
  function automatic void outcome(input logic t_rw, input int t_n, input logic pres,
                                  input int nack, output int m, output logic err);
    int n;
    n = (t_n > MAXB) ? MAXB : t_n;
    if (!pres) begin
      m = 0; err = 1;
    end else if (!t_rw && nack >= 0 && nack < n) begin
      m = nack + 1; err = 1;
    end else begin
      m = n; err = 0;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input string tag, input logic t_rw, input logic [6:0] t_addr,
                         input int t_n, input logic [31:0] t_wd, input logic t_present,
                         input int t_nack, input logic [31:0] t_rd, input logic exp_err,
                         input int exp_m, input logic t_stretch, input logic t_poke);
    int   cyc, exp_cyc, stop0, lo;
    logic seen;
    exp_q.delete();
    exp_mack.delete();
    exp_q.push_back({t_addr, t_rw});
    for (int k = 0; k < exp_m; k++) begin
      if (!t_rw) exp_q.push_back(t_wd[8*k +: 8]);
      else begin
        exp_mack.push_back(k == exp_m - 1);
        rdata_model[8*k +: 8] = t_rd[8*k +: 8];
      end
    end
    exp_cyc = (2 + 36 * (1 + exp_m) + 3) * QDIV;

    @(negedge clk);
    cfg_present = t_present; cfg_nack = t_nack; cfg_rd = t_rd; cfg_stretch = t_stretch;
    rw = t_rw; addr = t_addr; nbytes = LW'(t_n); wdata = t_wd; start = 1'b1;
    stop0 = stop_cnt;
    cyc = 0; seen = 0;
    while (!seen && cyc < exp_cyc + 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1'b1);
      end
      if (t_poke && cyc == 60) begin
        start = 1'b1; addr = t_addr ^ 7'h55; rw = ~t_rw; nbytes = LW'(1);
      end
      if (t_poke && cyc == 61) start = 1'b0;
      if (done) seen = 1;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    if (!seen) begin
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      rdata_model = '0;
      return;
    end
    lo = t_stretch ? exp_cyc + 50 : exp_cyc - 1;
    check_range({tag, "_cycles"}, cyc - 1, lo, t_stretch ? exp_cyc + 52 : exp_cyc + 1);
    check({tag, "_ack_err"}, ack_err, exp_err);
    check({tag, "_busy_fall"}, busy, 1'b0);
    check({tag, "_stop"}, stop_cnt - stop0, 1);
    check({tag, "_nbus"}, bus_bytes.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < bus_bytes.size(); k++)
      check({tag, "_byte"}, bus_bytes[k], exp_q[k]);
    check({tag, "_nmack"}, mack_q.size(), exp_mack.size());
    for (int k = 0; k < exp_mack.size() && k < mack_q.size(); k++)
      check({tag, "_mack"}, mack_q[k], exp_mack[k]);
    check({tag, "_rdata"}, rdata, rdata_model);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    if (t_poke) begin
      repeat (4 * QDIV) @(posedge clk);
      #1 check({tag, "_no_restart"}, busy, 1'b0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    int          n;
    logic [31:0] wd;
    logic        present;
    int          nack;
    logic [31:0] rd;
    logic        exp_err;
    int          exp_m;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int          m;
    logic        err;
    logic        r_rw, r_pres;
    int          r_n, r_nack;
    logic [6:0]  r_addr;
    logic [31:0] r_wd, r_rd;

    tbl[0] = '{1'b0, 7'h48, 2, 32'h0000A55A, 1'b1, -1, 32'h0,        1'b0, 2};
    tbl[1] = '{1'b0, 7'h21, 0, 32'h0,        1'b0, -1, 32'h0,        1'b1, 0};
    tbl[2] = '{1'b1, 7'h48, 3, 32'h0,        1'b1, -1, 32'h00332211, 1'b0, 3};
    tbl[3] = '{1'b0, 7'h48, 7, 32'hDEADBEEF, 1'b1, -1, 32'h0,        1'b0, 4};
    tbl[4] = '{1'b0, 7'h3C, 3, 32'h00C3B2A1, 1'b1,  1, 32'h0,        1'b1, 2};
    tbl[5] = '{1'b0, 7'h7F, 0, 32'h0,        1'b1, -1, 32'h0,        1'b0, 0};
    tbl[6] = '{1'b1, 7'h10, 7, 32'h0,        1'b1, -1, 32'h89ABCDEF, 1'b0, 4};
    tbl[7] = '{1'b1, 7'h55, 2, 32'h0,        1'b0, -1, 32'h12345678, 1'b1, 0};
    tbl[8] = '{1'b1, 7'h01, 1, 32'h0,        1'b1, -1, 32'h0000005A, 1'b0, 1};

    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; nbytes = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl_oe", scl_oe, 1'b0);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].rw, tbl[i].addr, tbl[i].n, tbl[i].wd,
              tbl[i].present, tbl[i].nack, tbl[i].rd, tbl[i].exp_err, tbl[i].exp_m, 1'b0, 1'b0);

    // start pulsed mid-transaction must not disturb it or queue a second one
    run_txn("poke", 1'b0, 7'h48, 2, 32'h00006699, 1'b1, -1, 32'h0, 1'b0, 2, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      r_rw   = 1'($urandom_range(0, 1));
      r_addr = 7'($urandom_range(0, 127));
      r_n    = int'($urandom_range(0, 7));
      r_wd   = $urandom;
      r_rd   = $urandom;
      r_pres = ($urandom_range(0, 7) != 0);
      r_nack = int'($urandom_range(0, 5)) - 2;
      outcome(r_rw, r_n, r_pres, r_nack, m, err);
      run_txn($sformatf("rnd%0d", i), r_rw, r_addr, r_n, r_wd, r_pres, r_nack, r_rd,
              err, m, 1'b0, 1'b0);
    end

    // reset during data byte 1 of a write: lines drop at once, no done
    begin
      int dcount;
      @(negedge clk);
      cfg_present = 1'b1; cfg_nack = -1; cfg_stretch = 1'b0;
      rw = 1'b0; addr = 7'h48; nbytes = LW'(2); wdata = 32'h00001234; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat ((2 + 36 * 2) * QDIV + 1) @(posedge clk);
      #1;
      check("mid_pre_scl", scl_oe, 1'b1);
      check("mid_pre_sda", sda_oe, 1'b1);
      @(negedge clk) reset = 1'b1;
      #1;
      check("mid_rst_scl", scl_oe, 1'b0);
      check("mid_rst_sda", sda_oe, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      rdata_model = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      dcount = 0;
      repeat (40 * QDIV) begin
        @(posedge clk); #1;
        if (done) dcount++;
      end
      check("mid_no_done", dcount, 0);
    end
    run_txn("after_rst", 1'b0, 7'h48, 2, 32'h0000A55A, 1'b1, -1, 32'h0, 1'b0, 2, 1'b0, 1'b0);

`ifdef I2C_CLOCK_STRETCH_EN
    run_txn("stretch", 1'b0, 7'h48, 2, 32'h00003CC3, 1'b1, -1, 32'h0, 1'b0, 2, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
